// File: rtl/regfile_param.sv
// Parameterised register file: two write ports (E, M; M wins on collision) and three registered read ports.
// Optional macro REGFILE_BYPASS_EN makes reads see the value written on the same edge.
module regfile_param #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [3:0]              dstE,
    input  logic [DATA_W-1:0]       valE,
    input  logic [3:0]              dstM,
    input  logic [DATA_W-1:0]       valM,
    input  logic [3:0]              rA,
    input  logic [3:0]              rB,
    input  logic [3:0]              rID,
    output logic [DATA_W-1:0]       valA,
    output logic [DATA_W-1:0]       valB,
    output logic [DATA_W-1:0]       rdata,
    output logic [NREGS*DATA_W-1:0] regs_flat,
    output logic                    wr_conflict
);

    typedef logic [NREGS-1:0][DATA_W-1:0] regArrT;

    regArrT            regs_q, regs_d, readSrc;
    logic [DATA_W-1:0] valA_q, valA_d;
    logic [DATA_W-1:0] valB_q, valB_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              wrConflict_q, wrConflict_d;
    logic              dstEValid, dstMValid;

    function automatic logic idValid(input logic [3:0] id);
        return int'(id) < NREGS;
    endfunction

    // IDs outside the implemented range never match an entry, so they read as zero.
    function automatic logic [DATA_W-1:0] readReg(input regArrT src, input logic [3:0] id);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (id == 4'(i)) begin
                r = src[i];
            end
        end
        return r;
    endfunction

    assign dstEValid = idValid(dstE);
    assign dstMValid = idValid(dstM);

    // Port M is applied after port E so it overrides E when both name the same register.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NREGS; i++) begin
            if (dstEValid && dstE == 4'(i)) begin
                regs_d[i] = valE;
            end
        end
        for (int i = 0; i < NREGS; i++) begin
            if (dstMValid && dstM == 4'(i)) begin
                regs_d[i] = valM;
            end
        end
        wrConflict_d = dstEValid && dstMValid && (dstE == dstM);
    end

`ifdef REGFILE_BYPASS_EN
    assign readSrc = regs_d;
`else
    assign readSrc = regs_q;
`endif

    always_comb begin
        valA_d  = readReg(readSrc, rA);
        valB_d  = readReg(readSrc, rB);
        rdata_d = readReg(readSrc, rID);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regs_q       <= '0;
            valA_q       <= '0;
            valB_q       <= '0;
            rdata_q      <= '0;
            wrConflict_q <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            valA_q       <= valA_d;
            valB_q       <= valB_d;
            rdata_q      <= rdata_d;
            wrConflict_q <= wrConflict_d;
        end
    end

    assign valA        = valA_q;
    assign valB        = valB_q;
    assign rdata       = rdata_q;
    assign wr_conflict = wrConflict_q;
    assign regs_flat   = regs_q;

endmodule

// File: tb/tb_regfile_param.sv
// Randomised self-checking bench for regfile_param against an array-based reference model,
// plus directed literal checks and a DATA_W=16 / NREGS=15 instance.
module tb_regfile_param;

    localparam int DW = 32;
    localparam int NR = 8;

    logic            clock;
    logic            reset_n;
    logic [3:0]      dstE, dstM, rA, rB, rID;
    logic [DW-1:0]   valE, valM;
    logic [DW-1:0]   valA, valB, rdata;
    logic [NR*DW-1:0] regs_flat;
    logic            wr_conflict;

    logic [3:0]      sDstE, sDstM, sRA, sRB, sRID;
    logic [15:0]     sValE, sValM, sValA, sValB, sRdata;
    logic [15*16-1:0] sRegsFlat;
    logic            sConflict;

    int total = 0;
    int bad   = 0;
    bit checkEn = 0;

    logic [DW-1:0] mdl [16];
    logic [DW-1:0] expA, expB, expR;
    logic          expConf;

    regfile_param #(.DATA_W(DW), .NREGS(NR)) dut (
        .clock(clock), .reset_n(reset_n),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .rA(rA), .rB(rB), .rID(rID),
        .valA(valA), .valB(valB), .rdata(rdata),
        .regs_flat(regs_flat), .wr_conflict(wr_conflict)
    );

    regfile_param #(.DATA_W(16), .NREGS(15)) dutSweep (
        .clock(clock), .reset_n(reset_n),
        .dstE(sDstE), .valE(sValE), .dstM(sDstM), .valM(sValM),
        .rA(sRA), .rB(sRB), .rID(sRID),
        .valA(sValA), .valB(sValB), .rdata(sRdata),
        .regs_flat(sRegsFlat), .wr_conflict(sConflict)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    // Reference model: whole-array semantics, old/new snapshot chooses bypass behaviour.
    always @(posedge clock or negedge reset_n) begin
        logic [DW-1:0] oldR [16];
        logic [DW-1:0] newR [16];
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) mdl[i] = '0;
            expA = '0; expB = '0; expR = '0; expConf = 0;
        end else begin
            oldR = mdl;
            newR = mdl;
            if (dstE < NR) newR[dstE] = valE;
            if (dstM < NR) newR[dstM] = valM;
            expConf = (dstE < NR) && (dstE == dstM);
`ifdef REGFILE_BYPASS_EN
            expA = (rA  < NR) ? newR[rA]  : '0;
            expB = (rB  < NR) ? newR[rB]  : '0;
            expR = (rID < NR) ? newR[rID] : '0;
`else
            expA = (rA  < NR) ? oldR[rA]  : '0;
            expB = (rB  < NR) ? oldR[rB]  : '0;
            expR = (rID < NR) ? oldR[rID] : '0;
`endif
            mdl = newR;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (checkEn) begin
            checkOutput("valA", 64'(valA), 64'(expA));
            checkOutput("valB", 64'(valB), 64'(expB));
            checkOutput("rdata", 64'(rdata), 64'(expR));
            checkOutput("wr_conflict", 64'(wr_conflict), 64'(expConf));
            for (int i = 0; i < NR; i++)
                checkOutput("reg", 64'(regs_flat[i*DW +: DW]), 64'(mdl[i]));
        end
    end

    task automatic applyStimulus(input logic [3:0] eId, input logic [DW-1:0] eVal,
                                 input logic [3:0] mId, input logic [DW-1:0] mVal,
                                 input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
        @(negedge clock);
        dstE = eId; valE = eVal; dstM = mId; valM = mVal;
        rA = a; rB = b; rID = d;
    endtask

    initial begin
        reset_n = 0;
        dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0; rA = 0; rB = 0; rID = 0;
        sDstE = 4'hF; sDstM = 4'hF; sValE = '0; sValM = '0; sRA = 0; sRB = 0; sRID = 0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_valA", 64'(valA), 64'h0);
        checkOutput("rst_regs", 64'(regs_flat[63:0]), 64'h0);
        checkOutput("rst_conflict", 64'(wr_conflict), 64'h0);
        @(negedge clock);
        reset_n = 1;
        checkEn = 1;

        // Dual write, then read both back
        applyStimulus(4'd1, 32'hAAAA, 4'd3, 32'h5555, 4'd0, 4'd0, 4'd0);
        applyStimulus(4'hF, 32'h0, 4'hF, 32'h0, 4'd1, 4'd3, 4'd1);
        @(posedge clock); #1;
        checkOutput("dual_valA", 64'(valA), 64'hAAAA);
        checkOutput("dual_valB", 64'(valB), 64'h5555);
        checkOutput("dual_rdata", 64'(rdata), 64'hAAAA);

        // Collision on r4: M wins, conflict pulses once
        applyStimulus(4'd4, 32'h11, 4'd4, 32'h22, 4'd0, 4'd0, 4'd0);
        @(posedge clock); #1;
        checkOutput("coll_r4", 64'(regs_flat[4*DW +: DW]), 64'h22);
        checkOutput("coll_pulse", 64'(wr_conflict), 64'h1);
        applyStimulus(4'hF, 32'h0, 4'hF, 32'h0, 4'd4, 4'd4, 4'd4);
        @(posedge clock); #1;
        checkOutput("coll_clear", 64'(wr_conflict), 64'h0);
        checkOutput("coll_valA", 64'(valA), 64'h22);

        // Invalid IDs write nothing and read zero
        applyStimulus(4'd9, 32'hDEAD, 4'hF, 32'hBEEF, 4'd12, 4'd4, 4'd15);
        @(posedge clock); #1;
        checkOutput("inv_valA", 64'(valA), 64'h0);
        checkOutput("inv_rdata", 64'(rdata), 64'h0);
        checkOutput("inv_r4", 64'(regs_flat[4*DW +: DW]), 64'h22);

        // Same-edge write and read of r5
        applyStimulus(4'd5, 32'h10, 4'hF, 32'h0, 4'd0, 4'd0, 4'd0);
        applyStimulus(4'd5, 32'h99, 4'hF, 32'h0, 4'd5, 4'd0, 4'd0);
        @(posedge clock); #1;
`ifdef REGFILE_BYPASS_EN
        checkOutput("bypass_valA", 64'(valA), 64'h99);
`else
        checkOutput("bypass_valA", 64'(valA), 64'h10);
`endif

        // Mid-cycle reset clears everything before the next edge
        applyStimulus(4'd2, 32'h1234, 4'd2, 32'h1234, 4'd0, 4'd0, 4'd0);
        applyStimulus(4'd6, 32'h77, 4'hF, 32'h0, 4'd2, 4'd2, 4'd2);
        @(posedge clock); #1;
        checkOutput("pre_rst_valA", 64'(valA), 64'h1234);
        #2 reset_n = 0;
        #1;
        checkOutput("mid_rst_r2", 64'(regs_flat[2*DW +: DW]), 64'h0);
        checkOutput("mid_rst_valA", 64'(valA), 64'h0);
        checkOutput("mid_rst_valB", 64'(valB), 64'h0);
        checkOutput("mid_rst_rdata", 64'(rdata), 64'h0);
        checkOutput("mid_rst_conflict", 64'(wr_conflict), 64'h0);
        @(negedge clock);
        reset_n = 1;
        @(posedge clock); #1;
        checkOutput("post_rst_r6", 64'(regs_flat[6*DW +: DW]), 64'h77);

        // Wider register count, narrower data
        @(negedge clock);
        sDstE = 4'd14; sValE = 16'hBEEF;
        @(negedge clock);
        sDstE = 4'hF; sRID = 4'd14; sDstM = 4'hF; sValM = 16'h1111;
        @(posedge clock); #1;
        checkOutput("sweep_rdata", 64'(sRdata), 64'hBEEF);
        checkOutput("sweep_flat", 64'(sRegsFlat[239:224]), 64'hBEEF);

        // Randomised traffic with biased collisions and occasional resets
        for (int n = 0; n < 400; n++) begin
            logic [3:0] e, m;
            e = 4'($urandom_range(0, 15));
            m = ($urandom_range(0, 3) == 0) ? e : 4'($urandom_range(0, 15));
            applyStimulus(e, $urandom, m, $urandom,
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)));
            if ($urandom_range(0, 60) == 0) begin
                @(posedge clock);
                #3 reset_n = 0;
                @(negedge clock);
                reset_n = 1;
            end
        end
        @(negedge clock);
        @(negedge clock);
        checkEn = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
